// File: rtl/clint_mh_if.sv
`default_nettype none
// ============================================================================
// clint_mh_if : 64-bit AXI-lite bundle between the crossbar and clint_mh.
// Rev 1.0
// ============================================================================
interface clint_mh_if;
    logic [15:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
`ifdef CLINT_WSTRB_EN
    logic [7:0]  wstrb;
`endif
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [15:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

`ifdef CLINT_WSTRB_EN
    modport master (output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
                    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid);
    modport slave  (input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
                    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid);
`else
    modport master (output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
                    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid);
    modport slave  (input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
                    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid);
`endif
endinterface
`default_nettype wire

// File: rtl/clint_mh.sv
`default_nettype none
// ============================================================================
// clint_mh : multi-hart core-local interruptor, shared mtime + per-hart msip/mtimecmp.
// Optional byte strobes on writes when CLINT_WSTRB_EN is defined.   Rev 1.0
// ============================================================================
module clint_mh #(
    parameter int NHARTS  = 1,
    parameter int CPUFREQ = 20000000,
    parameter int TBFREQ  = 10000000
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    output logic [NHARTS-1:0]      msip_o,
    output logic [NHARTS-1:0]      mtip_o,
    output logic [63:0]            int_time,
    clint_mh_if.slave              s_axi
);
    localparam int          C_DIV       = CPUFREQ / TBFREQ;
    localparam logic [31:0] C_PRESC_MAX = 32'(C_DIV - 1);
    localparam int          C_HW        = (NHARTS > 1) ? $clog2(NHARTS) : 1;
    localparam logic [1:0]  C_OKAY      = 2'b00;
    localparam logic [1:0]  C_SLVERR    = 2'b10;

    typedef enum logic [1:0] {SEL_NONE, SEL_MSIP, SEL_CMP, SEL_TIME} sel_e;

    // Full decode: misaligned offsets and harts beyond NHARTS fall through to SEL_NONE.
    function automatic sel_e decode(input logic [15:0] addr);
        decode = SEL_NONE;
        if (addr == 16'hBFF8) begin
            decode = SEL_TIME;
        end else if (addr[2:0] == 3'b000 && int'(addr[13:3]) < NHARTS) begin
            if (addr[15:14] == 2'b00)      decode = SEL_MSIP;
            else if (addr[15:14] == 2'b01) decode = SEL_CMP;
        end
    endfunction

    logic [63:0]     r_mtime;
    logic [31:0]     r_presc;
    logic            r_msip [NHARTS];
    logic [63:0]     r_cmp  [NHARTS];
    logic            r_msip_q [NHARTS];
    logic            r_mtip_q [NHARTS];
    logic [15:0]     r_awaddr;
    logic [63:0]     r_wdata;
    logic            w_tick;
    logic            w_commit;
    sel_e            w_wsel;
    sel_e            w_rsel;
    logic [C_HW-1:0] w_aw_idx;
    logic [C_HW-1:0] w_ar_idx;
    logic [63:0]     w_wmask;
    logic [63:0]     w_rd_data;
    logic            w_rd_err;

`ifdef CLINT_WSTRB_EN
    logic [7:0]      r_wstrb;
    for (genvar i = 0; i < 8; i++) begin : g_mask
        assign w_wmask[i*8 +: 8] = {8{r_wstrb[i]}};
    end
`else
    assign w_wmask = '1;
`endif

    assign w_tick   = (r_presc == C_PRESC_MAX);
    // Both halves captured (readies low) and no response pending: this is the commit cycle.
    assign w_commit = !s_axi.awready && !s_axi.wready && !s_axi.bvalid;
    assign w_wsel   = decode(r_awaddr);
    assign w_rsel   = decode(s_axi.araddr);
    assign w_aw_idx = r_awaddr[3 +: C_HW];
    assign w_ar_idx = s_axi.araddr[3 +: C_HW];
    assign int_time = r_mtime;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_mtime <= '0;
        end else begin
            if (w_tick) begin
                r_presc <= '0;
                r_mtime <= r_mtime + 64'd1;
            end else begin
                r_presc <= r_presc + 32'd1;
            end
            if (w_commit && w_wsel == SEL_TIME)
                r_mtime <= (r_mtime & ~w_wmask) | (r_wdata & w_wmask);
        end
    end

    for (genvar h = 0; h < NHARTS; h++) begin : g_hart
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_msip[h]   <= 1'b0;
                r_cmp[h]    <= '1;
                r_msip_q[h] <= 1'b0;
                r_mtip_q[h] <= 1'b0;
            end else begin
                if (w_commit && w_wsel == SEL_MSIP && int'(w_aw_idx) == h && w_wmask[0])
                    r_msip[h] <= r_wdata[0];
                if (w_commit && w_wsel == SEL_CMP && int'(w_aw_idx) == h)
                    r_cmp[h] <= (r_cmp[h] & ~w_wmask) | (r_wdata & w_wmask);
                r_msip_q[h] <= r_msip[h];
                r_mtip_q[h] <= (r_mtime >= r_cmp[h]);
            end
        end
        assign msip_o[h] = r_msip_q[h];
        assign mtip_o[h] = r_mtip_q[h];
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        case (w_rsel)
            SEL_MSIP: w_rd_data = {63'b0, r_msip[w_ar_idx]};
            SEL_CMP:  w_rd_data = r_cmp[w_ar_idx];
            SEL_TIME: w_rd_data = r_mtime;
            default:  w_rd_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_axi.arready <= 1'b1;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
            s_axi.rresp   <= C_OKAY;
            s_axi.awready <= 1'b1;
            s_axi.wready  <= 1'b1;
            s_axi.bvalid  <= 1'b0;
            s_axi.bresp   <= C_OKAY;
            r_awaddr      <= '0;
            r_wdata       <= '0;
`ifdef CLINT_WSTRB_EN
            r_wstrb       <= '0;
`endif
        end else begin
            if (s_axi.arvalid && s_axi.arready) begin
                s_axi.rdata   <= w_rd_data;
                s_axi.rresp   <= w_rd_err ? C_SLVERR : C_OKAY;
                s_axi.rvalid  <= 1'b1;
                s_axi.arready <= 1'b0;
            end else if (s_axi.rvalid && s_axi.rready) begin
                s_axi.rvalid  <= 1'b0;
                s_axi.arready <= 1'b1;
            end

            if (s_axi.awvalid && s_axi.awready) begin
                r_awaddr      <= s_axi.awaddr;
                s_axi.awready <= 1'b0;
            end
            if (s_axi.wvalid && s_axi.wready) begin
                r_wdata       <= s_axi.wdata;
`ifdef CLINT_WSTRB_EN
                r_wstrb       <= s_axi.wstrb;
`endif
                s_axi.wready  <= 1'b0;
            end
            if (w_commit) begin
                s_axi.bvalid  <= 1'b1;
                s_axi.bresp   <= (w_wsel == SEL_NONE) ? C_SLVERR : C_OKAY;
            end else if (s_axi.bvalid && s_axi.bready) begin
                s_axi.bvalid  <= 1'b0;
                s_axi.awready <= 1'b1;
                s_axi.wready  <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_clint_mh.sv
`default_nettype none
// tb_clint_mh : table vectors, hand-written corner sequences and randomized traffic
// against a behavioural CLINT model (two harts, DIV = 2).
module tb_clint_mh;
    localparam int         NHARTS  = 2;
    localparam int         CPUFREQ = 20000000;
    localparam int         TBFREQ  = 10000000;
    localparam int         DIV     = CPUFREQ / TBFREQ;
    localparam logic [1:0] OKAY    = 2'b00;
    localparam logic [1:0] SLVERR  = 2'b10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NHARTS-1:0] msip_o;
    logic [NHARTS-1:0] mtip_o;
    logic [63:0]       int_time;

    clint_mh_if bus();

    clint_mh #(.NHARTS(NHARTS), .CPUFREQ(CPUFREQ), .TBFREQ(TBFREQ)) dut (
        .clk(clk), .rst_n(rst_n), .msip_o(msip_o), .mtip_o(mtip_o),
        .int_time(int_time), .s_axi(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    longint unsigned cyc = 0;          // posedges since reset release
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    // Behavioural model state
    logic            msip_m [NHARTS];
    logic [63:0]     cmp_m  [NHARTS];
    logic [63:0]     mt_base;
    longint unsigned mt_edge;
    logic [NHARTS-1:0] msip_at_b;
`ifdef CLINT_WSTRB_EN
    logic [7:0]      wr_strb = 8'hFF;
`endif

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;
    vec_t tbl [16];

    logic [63:0]     rdat;
    logic [1:0]      rsp;
    longint unsigned hs, cm;
    logic [63:0]     old_v;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        failures++;
        $display("FAIL %s: timed out waiting for DUT", name);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // mtime after posedge n: one increment every DIV edges since reset, offset by any write.
    function automatic logic [63:0] exp_time(input longint unsigned n);
        exp_time = mt_base + 64'(n / DIV) - 64'(mt_edge / DIV);
    endfunction

    function automatic int decode_addr(input logic [15:0] a, output int h);
        int unsigned ai;
        ai = 32'(a);
        h = 0;
        decode_addr = 0;
        if (ai == 32'hBFF8) decode_addr = 3;
        else if (ai % 8 == 0) begin
            if (ai < 32'h4000 && ai / 8 < NHARTS) begin
                h = int'(ai / 8); decode_addr = 1;
            end else if (ai >= 32'h4000 && ai < 32'h8000 && (ai - 32'h4000) / 8 < NHARTS) begin
                h = int'((ai - 32'h4000) / 8); decode_addr = 2;
            end
        end
    endfunction

    function automatic logic [63:0] cur_mask();
`ifdef CLINT_WSTRB_EN
        for (int i = 0; i < 8; i++) cur_mask[i*8 +: 8] = wr_strb[i] ? 8'hFF : 8'h00;
`else
        cur_mask = '1;
`endif
    endfunction

    task automatic bus_idle();
        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wvalid = 0; bus.bready = 0;
        bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
`ifdef CLINT_WSTRB_EN
        bus.wstrb = 8'hFF;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        bus_idle();
        repeat (2) @(negedge clk);
        rst_n = 1;
        mt_base = '0;
        mt_edge = 0;
        for (int h = 0; h < NHARTS; h++) begin
            msip_m[h] = 1'b0;
            cmp_m[h]  = '1;
        end
    endtask

    // All bus tasks are entered and left just after a negedge.
    task automatic axi_read(input logic [15:0] a, output logic [63:0] d, output logic [1:0] r,
                            output longint unsigned hsx);
        int n;
        bus.araddr = a; bus.arvalid = 1;
        n = 0;
        while (!bus.arready && n < 50) begin @(negedge clk); n++; end
        if (!bus.arready) timeout("arready");
        hsx = cyc + 1;
        @(negedge clk);
        bus.arvalid = 0;
        check64("rvalid_latency", 64'(bus.rvalid), 64'd1);
        d = bus.rdata; r = bus.rresp;
        bus.rready = 1;
        @(negedge clk);
        bus.rready = 0;
        check64("arready_after_r", 64'(bus.arready), 64'd1);
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [63:0] d, output logic [1:0] r,
                             output longint unsigned c);
        int n;
        bus.awaddr = a; bus.awvalid = 1; bus.wdata = d; bus.wvalid = 1;
`ifdef CLINT_WSTRB_EN
        bus.wstrb = wr_strb;
`endif
        n = 0;
        while (!(bus.awready && bus.wready) && n < 50) begin @(negedge clk); n++; end
        if (!(bus.awready && bus.wready)) timeout("aw_w_ready");
        c = cyc + 2;
        @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0;
        check64("bvalid_early", 64'(bus.bvalid), 64'd0);
        @(negedge clk);
        check64("bvalid_latency", 64'(bus.bvalid), 64'd1);
        msip_at_b = msip_o;
        r = bus.bresp;
        bus.bready = 1;
        @(negedge clk);
        bus.bready = 0;
        check64("ready_after_b", 64'({bus.awready, bus.wready}), 64'd3);
    endtask

    task automatic rd(input logic [15:0] a);
        logic [63:0] d, e;
        logic [1:0] r;
        longint unsigned hx;
        int h, k;
        axi_read(a, d, r, hx);
        k = decode_addr(a, h);
        case (k)
            1:       e = {63'b0, msip_m[h]};
            2:       e = cmp_m[h];
            3:       e = exp_time(hx - 1);
            default: e = '0;
        endcase
        check64($sformatf("rdata@%h", a), d, e);
        check64($sformatf("rresp@%h", a), 64'(r), (k == 0) ? 64'(SLVERR) : 64'(OKAY));
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d);
        logic [1:0] r;
        longint unsigned c;
        logic [63:0] m;
        int h, k;
        axi_write(a, d, r, c);
        k = decode_addr(a, h);
        m = cur_mask();
        check64($sformatf("bresp@%h", a), 64'(r), (k == 0) ? 64'(SLVERR) : 64'(OKAY));
        case (k)
            1: if (m[0]) msip_m[h] = d[0];
            2: cmp_m[h] = (cmp_m[h] & ~m) | (d & m);
            3: begin
                mt_base = (exp_time(c - 1) & ~m) | (d & m);
                mt_edge = c;
            end
            default: ;
        endcase
    endtask

    task automatic check_irqs();
        logic [NHARTS-1:0] em, et;
        for (int h = 0; h < NHARTS; h++) begin
            em[h] = msip_m[h];
            et[h] = (exp_time(cyc - 1) >= cmp_m[h]);
        end
        check64("msip_o", 64'(msip_o), 64'(em));
        check64("mtip_o", 64'(mtip_o), 64'(et));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 16'h0000, 64'h0, 64'h0, OKAY};
        tbl[1]  = '{1'b0, 16'h4000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, OKAY};
        tbl[2]  = '{1'b0, 16'h4008, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, OKAY};
        tbl[3]  = '{1'b0, 16'h4010, 64'h0, 64'h0, SLVERR};
        tbl[4]  = '{1'b1, 16'h1234, 64'hDEAD, 64'h0, SLVERR};
        tbl[5]  = '{1'b1, 16'h0008, 64'h1, 64'h0, OKAY};
        tbl[6]  = '{1'b0, 16'h0008, 64'h0, 64'h1, OKAY};
        tbl[7]  = '{1'b1, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, OKAY};
        tbl[8]  = '{1'b0, 16'h0000, 64'h0, 64'h0, OKAY};
        tbl[9]  = '{1'b1, 16'h4000, 64'h1234_5678_9ABC_DEF0, 64'h0, OKAY};
        tbl[10] = '{1'b0, 16'h4000, 64'h0, 64'h1234_5678_9ABC_DEF0, OKAY};
        tbl[11] = '{1'b0, 16'h0004, 64'h0, 64'h0, SLVERR};
        tbl[12] = '{1'b0, 16'h0010, 64'h0, 64'h0, SLVERR};
        tbl[13] = '{1'b1, 16'h4010, 64'h5, 64'h0, SLVERR};
        tbl[14] = '{1'b0, 16'h4008, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, OKAY};
        tbl[15] = '{1'b0, 16'hBFF0, 64'h0, 64'h0, SLVERR};

        bus_idle();
        // Reset state and mtime progression with DIV = 2
        do_reset();
        rst_n = 0;
        @(negedge clk);
        check64("rst_outputs", {int_time[15:0], 6'b0, msip_o, mtip_o, 4'b0},
                64'h0);
        check64("rst_handshake", 64'({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid}),
                64'b11100);
        check64("rst_data", {bus.rdata[59:0], bus.rresp, bus.bresp}, 64'h0);
        rst_n = 1;
        check64("mtime_at_release", int_time, 64'd0);
        repeat (10) @(negedge clk);
        check64("mtime_10_cycles", int_time, 64'd5);
        rd(16'h4000);
        rd(16'hBFF8);

        // Table vectors
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].wr) begin
                axi_write(tbl[i].addr, tbl[i].wdata, rsp, cm);
            end else begin
                axi_read(tbl[i].addr, rdat, rsp, hs);
                check64($sformatf("tbl%0d_rdata", i), rdat, tbl[i].exp_data);
            end
            check64($sformatf("tbl%0d_resp", i), 64'(rsp), 64'(tbl[i].exp_resp));
        end
        check64("tbl_msip_o", 64'(msip_o), 64'b10);

        // Timer interrupt for hart 1 at mtimecmp = 20
        do_reset();
        wr(16'h4008, 64'd20);
        for (int i = 0; i < 60; i++) begin
            check64("mtip_h1", 64'(mtip_o), (exp_time(cyc - 1) >= 64'd20) ? 64'b10 : 64'b00);
            @(negedge clk);
        end
        check64("mtip_final", 64'(mtip_o), 64'b10);

        // Software interrupt one cycle after bvalid
        do_reset();
        wr(16'h0008, 64'd1);
        check64("msip_at_bvalid", 64'(msip_at_b), 64'b00);
        check64("msip_after_b", 64'(msip_o), 64'b10);
        rd(16'h0008);

        // W three cycles ahead of AW, B held off four cycles
        bus.wdata = 64'd7; bus.wvalid = 1; bus.awaddr = 16'h4000;
        @(negedge clk);
        bus.wvalid = 0;
        check64("w_only_ready", 64'({bus.awready, bus.wready}), 64'b10);
        repeat (2) @(negedge clk);
        bus.awvalid = 1;
        @(negedge clk);
        bus.awvalid = 0;
        check64("aw_dropped", 64'(bus.awready), 64'd0);
        @(negedge clk);
        check64("b_after_split", 64'(bus.bvalid), 64'd1);
        bus.awvalid = 1; bus.wvalid = 1; bus.wdata = 64'd9;
        repeat (4) begin
            check64("no_second_accept", 64'({bus.awready, bus.wready, bus.bvalid}), 64'b001);
            @(negedge clk);
        end
        bus.awvalid = 0; bus.wvalid = 0; bus.bready = 1;
        @(negedge clk);
        bus.bready = 0;
        repeat (2) begin
            check64("single_b", 64'(bus.bvalid), 64'd0);
            @(negedge clk);
        end
        cmp_m[0] = 64'd7;
        rd(16'h4000);

        // Read in the write-commit cycle returns the old value
        old_v = cmp_m[0];
        bus.awaddr = 16'h4000; bus.wdata = 64'hABCD; bus.awvalid = 1; bus.wvalid = 1;
        @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0;
        bus.araddr = 16'h4000; bus.arvalid = 1;
        @(negedge clk);
        bus.arvalid = 0;
        check64("commit_read_old", bus.rdata, old_v);
        check64("commit_bvalid", 64'({bus.rvalid, bus.bvalid}), 64'b11);
        bus.rready = 1; bus.bready = 1;
        @(negedge clk);
        bus.rready = 0; bus.bready = 0;
        cmp_m[0] = 64'hABCD;
        rd(16'h4000);

        // mtime writes at both prescaler phases, then wrap-around
        for (int k = 0; k < 2; k++) begin
            repeat (k) @(negedge clk);
            wr(16'hBFF8, 64'h1_0000_0000 + 64'(k));
            repeat (5) @(negedge clk);
            check64("mtime_written", int_time, exp_time(cyc));
            rd(16'hBFF8);
        end
        wr(16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFD);
        repeat (8) @(negedge clk);
        check64("mtime_wrap", int_time, exp_time(cyc));
        check_irqs();

`ifdef CLINT_WSTRB_EN
        wr(16'h4000, 64'h0);
        wr_strb = 8'h0F;
        wr(16'h4000, 64'hFFFF_FFFF_FFFF_FFFF);
        check64("wstrb_low_half", cmp_m[0], 64'h0000_0000_FFFF_FFFF);
        rd(16'h4000);
        wr_strb = 8'h00;
        wr(16'h4000, 64'h0);
        wr(16'h0000, 64'h1);
        rd(16'h4000);
        rd(16'h0000);
        wr_strb = 8'hFF;
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 120; i++) begin
            int sel;
            logic [15:0] a;
            logic [63:0] d;
            logic is_wr;
            sel = int'($urandom_range(0, 9));
            is_wr = 1'($urandom_range(0, 1));
            d = {$urandom, $urandom};
            if (sel <= 2) begin
                a = 16'(8 * $urandom_range(0, 2));
            end else if (sel <= 6) begin
                a = 16'(32'h4000 + 8 * $urandom_range(0, 2));
                if ($urandom_range(0, 3) != 0)
                    d = exp_time(cyc) + 64'($urandom_range(0, 24)) - 64'd8;
            end else if (sel == 7) begin
                a = 16'hBFF8;
                is_wr = 1'b0;
            end else if (sel == 8) begin
                a = 16'($urandom);
            end else begin
                a = 16'(8 * $urandom_range(0, 2047));
            end
            if (is_wr) wr(a, d);
            else       rd(a);
            repeat (2) @(negedge clk);
            check_irqs();
            check64("int_time", int_time, exp_time(cyc));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
